// File: rtl/stopwatch_lap_timer.sv
// Stopwatch with lap display: MM:SS:cc BCD counter, debounced buttons,
// four-state controller (idle/run/paused/overflow) and registered 7-seg outputs.
module stopwatch_lap_timer #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned TICK_HZ         = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MAX_MINUTES     = 99
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       hold,
  input  logic       lap,
  output logic [6:0] Hex1,
  output logic [6:0] Hex2,
  output logic [6:0] Hex3,
  output logic [6:0] Hex4,
  output logic [6:0] Hex5,
  output logic [6:0] Hex6,
  output logic       CLK_ind,
  output logic       Overflow,
  output logic       lap_active,
  output logic [8:0] OtherLED
);

  localparam int unsigned Div  = CLK_HZ / TICK_HZ;
  localparam int unsigned PscW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PscW-1:0] PscLast = PscW'(Div - 1);
  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0]     CntTerm = {4'(MAX_MINUTES / 10), 4'(MAX_MINUTES % 10),
                                         4'd5, 4'd9, 4'd9, 4'd9};

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StOvf} state_e;

  // Button index: 0 = start_stop, 1 = hold, 2 = lap. All active-low.
  logic [2:0]     raw;
  logic [2:0]     sync1_q, sync2_q, db_q, db_prev_q, press_q;
  logic [DbW-1:0] db_cnt_q [3];

  assign raw = {lap, hold, start_stop};

  // Synchronise, debounce and turn debounced falling edges into one-cycle press pulses.
  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1_q   <= 3'b111;
      sync2_q   <= 3'b111;
      db_q      <= 3'b111;
      db_prev_q <= 3'b111;
      press_q   <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      press_q   <= db_prev_q & ~db_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic ss_press, lap_press, hold_rel;
  assign ss_press  = press_q[0];
  assign lap_press = press_q[2];
  assign hold_rel  = db_q[1];  // 1 = hold not pressed, counting allowed

  // Digit-wise BCD increment of {m1,m0,s1,s0,c1,c0}; caller guarantees not at terminal.
  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    r = v;
    if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (r[7:4] != 4'd9) r[7:4] = r[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (r[11:8] != 4'd9) r[11:8] = r[11:8] + 4'd1;
        else begin
          r[11:8] = 4'd0;
          if (r[15:12] != 4'd5) r[15:12] = r[15:12] + 4'd1;
          else begin
            r[15:12] = 4'd0;
            if (r[19:16] != 4'd9) r[19:16] = r[19:16] + 4'd1;
            else begin
              r[19:16] = 4'd0;
              r[23:20] = r[23:20] + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [PscW-1:0] psc_q, psc_d;
  logic [23:0]     cnt_q, cnt_d, lap_q, lap_d;
  logic            lap_act_q, lap_act_d;
  logic            tick;
  logic [6:0]      hex_q [6];
  logic            clk_ind_q;
  logic [23:0]     disp;

  assign tick = (state_q == StRun) && (psc_q == PscLast);

  // Next-state: controller, prescaler, counter and lap latch.
  always_comb begin
    state_d   = state_q;
    psc_d     = psc_q;
    cnt_d     = cnt_q;
    lap_d     = lap_q;
    lap_act_d = lap_act_q;
    case (state_q)
      StIdle: begin
        if (ss_press) begin
          state_d = StRun;
          psc_d   = '0;
        end
      end
      StRun: begin
        psc_d = tick ? '0 : psc_q + 1'b1;
        // The overflow tick swallows any coincident button press.
        if (tick && hold_rel && (cnt_q == CntTerm)) begin
          state_d = StOvf;
        end else begin
          if (tick && hold_rel) cnt_d = bcd_inc(cnt_q);
          if (ss_press) begin
            state_d = StPaused;
          end else if (lap_press) begin
            if (!lap_act_q) begin
              lap_d     = cnt_q;  // pre-increment value on a coincident tick
              lap_act_d = 1'b1;
            end else begin
              lap_act_d = 1'b0;
            end
          end
        end
      end
      StPaused: begin
        if (ss_press) begin
          state_d = StRun;
        end else if (lap_press) begin
          state_d   = StIdle;
          cnt_d     = '0;
          lap_act_d = 1'b0;
        end
      end
      StOvf: begin
        if (lap_press) begin
          state_d   = StIdle;
          cnt_d     = '0;
          lap_act_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign disp = lap_act_q ? lap_q : cnt_q;

  // State registers plus registered segment decode and run indicator.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= StIdle;
      psc_q     <= '0;
      cnt_q     <= '0;
      lap_q     <= '0;
      lap_act_q <= 1'b0;
      clk_ind_q <= 1'b0;
      for (int i = 0; i < 6; i++) hex_q[i] <= 7'b1000000;
    end else begin
      state_q   <= state_d;
      psc_q     <= psc_d;
      cnt_q     <= cnt_d;
      lap_q     <= lap_d;
      lap_act_q <= lap_act_d;
      clk_ind_q <= (state_q == StRun) && (cnt_q[7:4] < 4'd5);
      for (int i = 0; i < 6; i++) hex_q[i] <= seg7(disp[23-4*i -: 4]);
    end
  end

  assign Hex1       = hex_q[0];
  assign Hex2       = hex_q[1];
  assign Hex3       = hex_q[2];
  assign Hex4       = hex_q[3];
  assign Hex5       = hex_q[4];
  assign Hex6       = hex_q[5];
  assign CLK_ind    = clk_ind_q;
  assign Overflow   = (state_q == StOvf);
  assign lap_active = lap_act_q;
  assign OtherLED   = '0;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Directed bench: dut_a uses 10 CLK per tick; dut_b uses 2 CLK per tick so the
// overflow path is reachable in a short run.
module tb_stopwatch_lap_timer;

  logic CLK = 1'b0;
  logic reset;
  logic ss, hd, lp, ss2, hd2, lp2;

  logic [6:0] a_h1, a_h2, a_h3, a_h4, a_h5, a_h6;
  logic [6:0] b_h1, b_h2, b_h3, b_h4, b_h5, b_h6;
  logic       a_ind, a_ovf, a_lapact, b_ind, b_ovf, b_lapact;
  logic [8:0] a_other, b_other;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  stopwatch_lap_timer #(
    .CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_CYCLES(4), .MAX_MINUTES(1)
  ) dut_a (
    .CLK(CLK), .reset(reset), .start_stop(ss), .hold(hd), .lap(lp),
    .Hex1(a_h1), .Hex2(a_h2), .Hex3(a_h3), .Hex4(a_h4), .Hex5(a_h5), .Hex6(a_h6),
    .CLK_ind(a_ind), .Overflow(a_ovf), .lap_active(a_lapact), .OtherLED(a_other)
  );

  stopwatch_lap_timer #(
    .CLK_HZ(200), .TICK_HZ(100), .DEBOUNCE_CYCLES(4), .MAX_MINUTES(1)
  ) dut_b (
    .CLK(CLK), .reset(reset), .start_stop(ss2), .hold(hd2), .lap(lp2),
    .Hex1(b_h1), .Hex2(b_h2), .Hex3(b_h3), .Hex4(b_h4), .Hex5(b_h5), .Hex6(b_h6),
    .CLK_ind(b_ind), .Overflow(b_ovf), .lap_active(b_lapact), .OtherLED(b_other)
  );

  function automatic logic [6:0] seg(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    chk(tag, {8'b0, got}, {8'b0, exp});
  endtask

  task automatic chk_a(input string tag, input int m1, m0, s1, s0, c1, c0);
    chk({tag, ".hex1"}, {2'b0, a_h1}, {2'b0, seg(m1)});
    chk({tag, ".hex2"}, {2'b0, a_h2}, {2'b0, seg(m0)});
    chk({tag, ".hex3"}, {2'b0, a_h3}, {2'b0, seg(s1)});
    chk({tag, ".hex4"}, {2'b0, a_h4}, {2'b0, seg(s0)});
    chk({tag, ".hex5"}, {2'b0, a_h5}, {2'b0, seg(c1)});
    chk({tag, ".hex6"}, {2'b0, a_h6}, {2'b0, seg(c0)});
  endtask

  task automatic chk_b(input string tag, input int m1, m0, s1, s0, c1, c0);
    chk({tag, ".hex1"}, {2'b0, b_h1}, {2'b0, seg(m1)});
    chk({tag, ".hex2"}, {2'b0, b_h2}, {2'b0, seg(m0)});
    chk({tag, ".hex3"}, {2'b0, b_h3}, {2'b0, seg(s1)});
    chk({tag, ".hex4"}, {2'b0, b_h4}, {2'b0, seg(s0)});
    chk({tag, ".hex5"}, {2'b0, b_h5}, {2'b0, seg(c1)});
    chk({tag, ".hex6"}, {2'b0, b_h6}, {2'b0, seg(c0)});
  endtask

  initial begin
    reset = 1'b1;
    ss = 1'b1; hd = 1'b1; lp = 1'b1;
    ss2 = 1'b1; hd2 = 1'b1; lp2 = 1'b1;

    // Reset and idle
    cyc(5);
    chk_a("rst", 0, 0, 0, 0, 0, 0);
    chk_bit("rst.ovf", a_ovf, 1'b0);
    chk_bit("rst.ind", a_ind, 1'b0);
    reset = 1'b0;
    cyc(100);
    chk_a("idle", 0, 0, 0, 0, 0, 0);
    chk_bit("idle.ind", a_ind, 1'b0);
    chk_bit("idle.ovf", a_ovf, 1'b0);
    chk_bit("idle.lap", a_lapact, 1'b0);
    chk("idle.other", a_other, 9'd0);

    // Start: RUN entered 8 edges after driving low (t0); ticks at t0+10k
    ss = 1'b0; cyc(10); ss = 1'b1;             // t0+2
    cyc(8);
    chk("tick.before", {2'b0, a_h6}, {2'b0, seg(0)});
    cyc(1);                                    // t0+11
    chk("tick.first", {2'b0, a_h6}, {2'b0, seg(1)});
    cyc(994);                                  // t0+1005
    chk_a("run1s", 0, 0, 0, 1, 0, 0);
    chk_bit("run1s.ind", a_ind, 1'b1);
    cyc(500);                                  // t0+1505
    chk_a("run150", 0, 0, 0, 1, 5, 0);
    chk_bit("run150.ind", a_ind, 1'b0);

    // Hold: only the tick at t0+1510 still counts; 1520..1710 are dropped
    hd = 1'b0; cyc(100);                       // t0+1605
    chk_a("hold", 0, 0, 0, 1, 5, 1);
    cyc(100); hd = 1'b1;                       // t0+1705
    cyc(100);                                  // t0+1805
    chk_a("resume", 0, 0, 0, 1, 6, 0);

    // Lap press lands on the tick at t0+2580 while count is 00:02:37
    cyc(767); lp = 1'b0; cyc(10); lp = 1'b1;   // t0+2582
    chk_bit("lap.act", a_lapact, 1'b1);
    chk_a("lap.frz", 0, 0, 0, 2, 3, 7);
    cyc(100);                                  // t0+2682
    chk_a("lap.keep", 0, 0, 0, 2, 3, 7);
    lp = 1'b0; cyc(10); lp = 1'b1;             // t0+2692, release at t0+2690
    chk_bit("lap.off", a_lapact, 1'b0);
    chk_a("lap.live", 0, 0, 0, 2, 4, 9);

    // Pause, clear to idle, run to 00:00:42, pause there, then reset
    ss = 1'b0; cyc(10); ss = 1'b1; cyc(10);
    lp = 1'b0; cyc(10); lp = 1'b1; cyc(10);
    chk_a("clear", 0, 0, 0, 0, 0, 0);
    chk_bit("clear.lap", a_lapact, 1'b0);
    ss = 1'b0; cyc(10); ss = 1'b1;             // t1+2
    cyc(415); ss = 1'b0; cyc(10); ss = 1'b1;   // pause at t1+425
    cyc(20);
    chk_a("pause42", 0, 0, 0, 0, 4, 2);
    chk_bit("pause42.ind", a_ind, 1'b0);
    cyc(20);
    chk_a("pause.frz", 0, 0, 0, 0, 4, 2);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk_a("rst.mid", 0, 0, 0, 0, 0, 0);

    // Simultaneous start_stop + lap in RUN with lap_active=1
    ss = 1'b0; cyc(10); ss = 1'b1; cyc(20);    // RUN at t2 = B+8
    lp = 1'b0; cyc(10); lp = 1'b1; cyc(10);    // capture on tick at t2+30
    chk_bit("lap2.act", a_lapact, 1'b1);
    chk_a("lap2", 0, 0, 0, 0, 0, 2);
    ss = 1'b0; lp = 1'b0; cyc(10); ss = 1'b1; lp = 1'b1; cyc(20);
    chk_bit("both.lap", a_lapact, 1'b1);
    chk_bit("both.ind", a_ind, 1'b0);
    lp = 1'b0; cyc(10); lp = 1'b1; cyc(10);    // PAUSED + lap -> IDLE
    chk_bit("both.idle.lap", a_lapact, 1'b0);
    chk_a("both.idle", 0, 0, 0, 0, 0, 0);

    // Overflow on dut_b: RUN at t3, tick every 2 edges, 12000th tick at t3+24000
    ss2 = 1'b0; cyc(10); ss2 = 1'b1;           // t3+2
    cyc(23990); ss2 = 1'b0;                    // press lands on the overflow tick
    cyc(7);                                    // t3+23999
    chk_b("ovf.pre", 0, 1, 5, 9, 9, 9);
    chk_bit("ovf.pre.flag", b_ovf, 1'b0);
    cyc(1);
    chk_bit("ovf.set", b_ovf, 1'b1);
    cyc(3); ss2 = 1'b1; cyc(30);
    chk_bit("ovf.hold", b_ovf, 1'b1);
    chk_b("ovf.sat", 0, 1, 5, 9, 9, 9);
    ss2 = 1'b0; cyc(10); ss2 = 1'b1; cyc(20);
    chk_bit("ovf.ssign", b_ovf, 1'b1);
    chk_b("ovf.ssign", 0, 1, 5, 9, 9, 9);
    lp2 = 1'b0; cyc(10); lp2 = 1'b1; cyc(10);
    chk_bit("ovf.clr", b_ovf, 1'b0);
    chk_bit("ovf.clr.lap", b_lapact, 1'b0);
    chk_b("ovf.clr", 0, 0, 0, 0, 0, 0);
    chk("ovf.other", b_other, 9'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap_timer.md
Name: stopwatch_lap_timer

Overview:
Parametrised successor to the board stopwatch. It counts MM:SS:cc in BCD from a configurable system clock and adds a lap (split) display. A debounced start/stop / hold / lap button set drives a four-state controller, and a saturating overflow state replaces wrap-around. Outputs feed the six on-board 7-segment displays and indicator LEDs directly.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
TICK_HZ, 100, count resolution in Hz (centisecond tick); CLK_HZ/TICK_HZ must be an integer ≥2
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required to accept a button level change
MAX_MINUTES, 99, terminal minute value (1..99)

Ports:
CLK  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
start_stop  input  1  raw button, active-low (1 = not pressed)
hold  input  1  raw button, active-low, level-sensitive freeze
lap  input  1  raw button, active-low, lap / clear
Hex1..Hex6  output  7 each  segments {g..a}, active-low; Hex1 = tens of minutes .. Hex6 = ones of centiseconds
CLK_ind  output  1  1 Hz running indicator
Overflow  output  1  terminal time reached
lap_active  output  1  display is showing a frozen lap value
OtherLED  output  9  tied 0

Behaviour:
- Reset (sampled on CLK rise while reset=1): BCD count = 00:00:00, lap latch = 0, prescaler = 0, state IDLE, debounced buttons = 1. Outputs: Hex1..6 show "0" (7'b1000000), CLK_ind=0, Overflow=0, lap_active=0. Reset overrides every other input in the same cycle, including mid-run.
- Button path: 2-FF synchroniser, then a debouncer that accepts a new level after DEBOUNCE_CYCLES consecutive equal samples. A press = debounced 1->0 edge, one-cycle pulse. A raw press held long enough takes effect exactly DEBOUNCE_CYCLES+3 CLK edges after the first edge that samples it low. Releases generate no action. hold uses the debounced level.
- Prescaler: counts 0..CLK_HZ/TICK_HZ-1 only in RUN. Emits tick on the terminal count. Cleared to 0 on entry to RUN from IDLE.
- States:
  - IDLE: count zero, no ticks. start_stop -> RUN.
  - RUN: each tick increments count unless debounced hold=0. While hold=0 the prescaler keeps running and ticks are discarded. start_stop -> PAUSED.
  - PAUSED: count frozen. start_stop -> RUN (prescaler resumes from held value). lap -> IDLE (count cleared, lap_active cleared).
  - OVF: entered on the tick that would advance MAX_MINUTES:59:99. Count saturates at MAX_MINUTES:59:99 and Overflow=1. start_stop ignored. lap -> IDLE with Overflow cleared.
- Count arithmetic: cc 00..99 carries into ss, ss 00..59 carries into mm, mm 00..MAX_MINUTES. Each is BCD-digit-wise; no binary-to-BCD conversion.
- Lap (RUN only): a press with lap_active=0 copies the count into the lap latch and sets lap_active. A press with lap_active=1 clears lap_active. Counting continues throughout.
- Display source: lap latch if lap_active=1, else live count. Segment decode is registered (1 cycle after source change).
- Simultaneous events:
  - start_stop and lap pressed in the same cycle: start_stop wins, lap dropped.
  - Lap capture coinciding with a tick latches the pre-increment value.
  - A start_stop press on the overflow tick is ignored.
- CLK_ind = 1 when state=RUN and cc tens digit < 5, else 0. It is registered.

Test Plan:
Use CLK_HZ=1000, TICK_HZ=100, DEBOUNCE_CYCLES=4, MAX_MINUTES=1 (10 CLK/tick).
1. Reset held 5 cycles, then released idle for 100 cycles -> Hex1..6 all 7'b1000000, Overflow=0, CLK_ind=0, state stays IDLE.
2. start_stop low 10 cycles, first RUN edge at t0 -> first tick at t0+10. After 1000 cycles count = 00:01:00. CLK_ind high for ticks cc=00..49, low for 50..99.
3. In RUN, hold low for 200 cycles -> count frozen for those ticks (within debounce latency). After release, count resumes with no skipped or extra tick.
4. At count 00:02:37 press lap -> display frozen at 00:02:37, lap_active=1, live count advances. Second lap press -> display shows live count, lap_active=0.
5. Run to 01:59:99, one more tick -> Overflow=1, display 01:59:99 held. start_stop ignored. lap press -> IDLE, 00:00:00, Overflow=0.
6. In PAUSED at 00:00:42 assert reset 1 cycle -> next edge 00:00:00, IDLE. start_stop and lap pressed together in RUN -> PAUSED, lap_active unchanged.
